// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding its 64-bit result in HI/LO.
// Every operation takes PREP (1) + CALC (WIDTH) + FIX (1) cycles.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude stays WIDTH bits wide, so the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, opnd_r, shreg_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               res_sign_r, rem_sign_r;

  logic latch_s, mt_s, prep_s, step_s, fix_s;
  logic               is_signed_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, div_diff_s;
  logic [WIDTH-1:0]   div_rem_nxt_s;
  logic               qbit_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_PREP;
        else       state_nxt_s = S_IDLE;
      end
      S_PREP: state_nxt_s = S_CALC;
      S_CALC: begin
        if (cnt_r == LAST_ITER) state_nxt_s = S_FIX;
        else                    state_nxt_s = S_CALC;
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    latch_s = 1'b0;
    mt_s    = 1'b0;
    prep_s  = 1'b0;
    step_s  = 1'b0;
    fix_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        latch_s = start;
        mt_s    = ~start;
      end
      S_PREP:  prep_s = 1'b1;
      S_CALC:  step_s = 1'b1;
      S_FIX:   fix_s  = 1'b1;
      default: begin
        latch_s = 1'b0;
        mt_s    = 1'b0;
      end
    endcase
  end

  // Iteration arithmetic and final sign correction
  always_comb begin
    is_signed_s   = ~op_r[0];
    a_mag_s       = magnitude(a_r, is_signed_s);
    b_mag_s       = magnitude(b_r, is_signed_s);
    mul_sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                    (shreg_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    rem_sh_s      = {acc_r[2*WIDTH-1:WIDTH], shreg_r[WIDTH-1]};
    div_diff_s    = rem_sh_s - {1'b0, opnd_r};
    qbit_s        = ~div_diff_s[WIDTH];
    div_rem_nxt_s = qbit_s ? div_diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
    prod_s        = res_sign_r ? neg_2w(acc_r) : acc_r;
    quot_s        = res_sign_r ? neg_w(shreg_r) : shreg_r;
    rem_s         = rem_sign_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    if (!op_r[1]) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (b_r == {WIDTH{1'b0}}) begin
      res_hi_s = a_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
    end
  end

  // Operand latch and iterative datapath: mul shifts shreg right, div shifts quotient into it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= 2'b00;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      shreg_r    <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= {CW{1'b0}};
      res_sign_r <= 1'b0;
      rem_sign_r <= 1'b0;
    end else if (latch_s) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end else if (prep_s) begin
      res_sign_r <= is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
      rem_sign_r <= is_signed_s & a_r[WIDTH-1];
      shreg_r    <= op_r[1] ? a_mag_s : b_mag_s;
      opnd_r     <= op_r[1] ? b_mag_s : a_mag_s;
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (step_s) begin
      if (op_r[1]) begin
        acc_r   <= {div_rem_nxt_s, acc_r[WIDTH-1:0]};
        shreg_r <= {shreg_r[WIDTH-2:0], qbit_s};
      end else begin
        acc_r   <= {mul_sum_s, acc_r[WIDTH-1:1]};
        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
      end
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Architectural HI/LO, done pulse and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi   <= {WIDTH{1'b0}};
      lo   <= {WIDTH{1'b0}};
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= fix_s;
      busy <= (state_nxt_s != S_IDLE);
      if (fix_s) begin
        hi <= res_hi_s;
        lo <= res_lo_s;
      end else if (mt_s) begin
        if (hi_wr) hi <= wdata;
        if (lo_wr) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a driver queues reference results, a monitor
// checks them on done and checks HI/LO hold steady while busy.
module tb_mul_div_unit;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        hi_wr = 1'b0, lo_wr = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] hi, lo, hold_hi, hold_lo;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  logic [31:0] arch_hi = 32'd0, arch_lo = 32'd0;
  logic prev_done = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS semantics from 64-bit integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: begin sq = sx * sy; return sq; end
      2'd1: begin uq = ux * uy; return uq; end
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle actual=busy expected=idle within 100 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic hw);
    logic [63:0] r;
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; a = x; b = y; hi_wr = hw; wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    start = 1'b0; hi_wr = 1'b0;
    r = ref_result(o, x, y);
    e.due = cyc + LAT;
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.hold_hi = arch_hi;
    e.hold_lo = arch_lo;
    sb.push_back(e);
    arch_hi = e.hi;
    arch_lo = e.lo;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    wait_idle();
    hi_wr = hw; lo_wr = lw; wdata = d;
    @(posedge clk);
    #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (hw) arch_hi = d;
    if (lw) arch_lo = d;
    check32("mt_hi", hi, arch_hi);
    check32("mt_lo", lo, arch_lo);
  endtask

  // Monitor: compare on done, and check HI/LO are frozen while busy
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done) begin
          check32("done_pulse", {31'd0, prev_done}, 32'd0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=done expected=no_op_pending");
          end else begin
            e = sb.pop_front();
            check32("hi", hi, e.hi);
            check32("lo", lo, e.lo);
            check32("latency", 32'(cyc), 32'(e.due));
          end
        end else if (busy && sb.size() != 0) begin
          check32("hold_hi", hi, sb[0].hold_hi);
          check32("hold_lo", lo, sb[0].hold_lo);
        end
      end
      prev_done = done;
    end
  end

  logic [1:0]  d_op [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd100};
  logic [31:0] d_b  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd7};

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    #1 reset_n = 1'b0;
    #2;
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) issue(d_op[i], d_a[i], d_b[i], 1'b0);
    drain();

    // start together with hi_wr in IDLE: start wins
    issue(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b1);
    drain();

    // start and MTHI during CALC are ignored
    issue(2'd1, 32'd5, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd3; hi_wr = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    start = 1'b0; hi_wr = 1'b0;
    drain();
    check32("ign_hi", hi, 32'd0);
    check32("ign_lo", lo, 32'd30);
    mt(1'b0, 1'b1, 32'h0000_ABCD);
    mt(1'b1, 1'b1, 32'h0BAD_F00D);

    // reset mid-CALC aborts and clears HI/LO
    issue(2'd1, 32'd7, 32'd8, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    arch_hi = 32'd0;
    arch_lo = 32'd0;
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // random back-to-back traffic with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(ro, ra, rb, 1'b0);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
